// File: rtl/logic_stage_pkg.sv
// Shared types for the logic result stage: op encoding and occupancy states.
package logic_stage_pkg;

  // Bitwise function selected per transaction.
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_NAND = 2'd1,
    OP_XNOR = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  // Occupancy of the output register (OR) and skid register (SK).
  // EMPTY: OR empty. ONE: OR full, SK empty. TWO: both full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/logic_result_stage_compute.sv
// Combinational bitwise function unit feeding the result stage.
// Reserved op yields a zero result with the error flag set.
module logic_op_compute
  import logic_stage_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_zero,
  output logic             o_err
);

  logic [WIDTH-1:0] w_y;
  logic             w_err;

  // Select the bitwise function; zero flag follows the computed result.
  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (op_e'(i_op))
      OP_AND:  w_y = i_a & i_b;
      OP_NAND: w_y = ~(i_a & i_b);
      OP_XNOR: w_y = ~(i_a ^ i_b);
      OP_RSVD: w_err = 1'b1;
    endcase
  end

  assign o_y    = w_y;
  assign o_zero = ~|w_y;
  assign o_err  = w_err;

endmodule

// File: rtl/logic_result_stage.sv
// Registered result stage with a two-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never drops and data never changes until that transfer occurs
// (reset excepted). in_ready comes straight from a flop.
module logic_result_stage
  import logic_stage_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_err,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] acc_count,
  output logic [1:0]       dbg_state
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             err;
    op_e              op;
  } result_t;

  occ_e             r_state;
  occ_e             w_state_nxt;
  logic             r_in_ready;
  result_t          r_or;
  result_t          r_sk;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_y;
  logic             w_zero;
  logic             w_err;
  result_t          w_res;
  logic             w_acc;
  logic             w_drain;
  logic             w_load_or_new;
  logic             w_load_or_sk;
  logic             w_load_sk;

  logic_op_compute #(.WIDTH(WIDTH)) u_compute (
    .i_a    (in_a),
    .i_b    (in_b),
    .i_op   (in_op),
    .o_y    (w_y),
    .o_zero (w_zero),
    .o_err  (w_err)
  );

  assign w_res   = '{y: w_y, zero: w_zero, err: w_err, op: op_e'(in_op)};
  assign w_acc   = in_valid && r_in_ready;
  assign w_drain = (r_state != EMPTY) && out_ready;

  // Occupancy next-state and register load selects.
  always_comb begin
    w_state_nxt   = r_state;
    w_load_or_new = 1'b0;
    w_load_or_sk  = 1'b0;
    w_load_sk     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt   = ONE;
          w_load_or_new = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && w_drain) begin
          w_load_or_new = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = TWO;
          w_load_sk   = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_drain) begin
          w_state_nxt  = ONE;
          w_load_or_sk = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State register; in_ready is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  // Output and skid data registers; SK only fills while OR is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_or <= '0;
      r_sk <= '0;
    end else begin
      if (w_load_or_new) r_or <= w_res;
      else if (w_load_or_sk) r_or <= r_sk;
      if (w_load_sk) r_sk <= w_res;
    end
  end

  // Saturating count of accepted transactions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_acc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_y     = r_or.y;
  assign out_zero  = r_or.zero;
  assign out_err   = r_or.err;
  assign out_op    = r_or.op;
  assign acc_count = r_count;
  assign dbg_state = r_state;

endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
- Registered result stage directly downstream of the AND/NAND/XNOR gate cells.
- Accepts operand pairs with an op select under valid/ready and computes the selected bitwise function across WIDTH bits.
- Registers the result with zero and error flags and presents it downstream with a skid buffer, giving full throughput and a registered in_ready.
- Keeps a saturating count of accepted transactions for debug.

Parameters:
- WIDTH, 8, operand/result bit width (>=1)
- CNT_W, 16, width of accepted-transaction counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  stage can accept; driven directly from a flop
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  2  0=AND, 1=NAND, 2=XNOR, 3=reserved
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_y  out  WIDTH  registered result
- out_zero  out  1  out_y == 0
- out_err  out  1  result produced from reserved op
- out_op  out  2  op that produced out_y
- acc_count  out  CNT_W  number of accepted inputs, saturating

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following hold on the next cycle:
  - out_valid=0, out_y=0, out_zero=0, out_err=0, out_op=0
  - skid entry empty; in_ready=1; acc_count=0
- Reset mid-transfer discards any held results. No partial state survives.
- Input accept: in_valid && in_ready at the edge.
- Output handshake: out_valid && out_ready at the edge.
- Compute, per bit i:
  - AND: a&b
  - NAND: ~(a&b)
  - XNOR: ~(a^b)
  - op 3: y=0, err=1
  - zero = ~|y, computed on the computed y.
- Latency: an accepted input appears on out_* at the next edge when the output register is empty or is being drained that cycle.
- Storage: two entries, the output register (OR) and the skid register (SK). SK is only ever filled while OR is full.
- States, by occupancy: EMPTY (OR empty), ONE (OR full, SK empty), TWO (both full).
- Transitions:
  - EMPTY: accept -> ONE, result loaded into OR.
  - ONE, accept and drain -> ONE; OR reloads with the new result. Throughput 1/cycle.
  - ONE, accept only -> TWO; new result into SK.
  - ONE, drain only -> EMPTY.
  - TWO, drain -> ONE; SK moves to OR. in_ready=0 in TWO, so no accept occurs.
- in_ready = registered !(next state == TWO). Upstream may therefore hold valid for at most one extra cycle before the stall becomes visible.
- Data stability: out_y, out_zero, out_err and out_op hold stable while out_valid=1 and out_ready=0.
- out_valid never drops without a handshake, except on reset.
- Ordering: results leave strictly in acceptance order.
- acc_count:
  - Increments on every accept.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Not affected by drains.
- in_valid while in_ready=0 is ignored; no state change, count unchanged.
- X on in_a/in_b/in_op while in_valid=0 must not propagate to outputs or count.

Decomposition:
- Package logic_stage_pkg holds:
  - op enum: OP_AND=2'd0, OP_NAND=2'd1, OP_XNOR=2'd2, OP_RSVD=2'd3
  - occupancy state enum: EMPTY/ONE/TWO
  - a result struct {y, zero, err, op}, parameterised through WIDTH in the stage
- One combinational sub-module, logic_op_compute:
  - inputs (a, b, op); outputs (y, zero, err)
  - instantiated once on the input path
  - the stage itself holds only registers, occupancy FSM and counter.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, acc_count=0; no result emitted after release until a new accept.
- Op coverage (WIDTH=8, A=0xF0, B=0xCC, out_ready=1) -> one cycle later:
  - AND: y=0xC0
  - NAND: y=0x3F
  - XNOR: y=0xC3
  - op 3: y=0x00, zero=1, err=1
  - out_op matches each input op
- Zero flag: AND with A=0x0F, B=0xF0 -> y=0x00, zero=1, err=0. XNOR with A=0x5A, B=0xA5 -> y=0x00, zero=1.
- Backpressure: 4 back-to-back accepts with out_ready=0 -> only 2 accepted (in_ready falls after the second). Data holds stable. Releasing out_ready drains in order, then the remaining 2 are accepted. acc_count=4.
- Streaming: 100 random ops with out_ready=1 -> 100 results in order, one per cycle after first, matching a reference model. acc_count=100.
- Saturation and reset: CNT_W=4, 20 accepts -> acc_count=15. Assert rst_n=0 while in state TWO -> both entries dropped, out_valid=0 next cycle.
